// File: rtl/line_raster.sv
// rtl/line_raster.sv - Bresenham line rasterizer, one clipped line in, one pixel per cycle out
//
// Purpose:
//   Accepts one clipped Line2D per line_valid/line_ready handshake. Lines with line_accept=0
//   are consumed and dropped. Accepted lines are walked with integer Bresenham. Each point is
//   emitted on a pix_valid/pix_ready stream, and pix_last marks the final point of the line.
//
// Configuration macro:
//   RASTER_INCLUSIVE_END_EN
//     defined   - the endpoint p is drawn, so an s==p line gives one pixel.
//     undefined - the line is half-open [s,p) and p is never drawn, so an s==p line gives
//                 no pixels. Joints in polylines are then drawn only once.
//
// Ports:
//   clk          system clock
//   rst          synchronous reset, active-high
//   line_valid   line_in/line_accept valid
//   line_ready   block can take a line (IDLE only)
//   line_in      clipped line: .s start, .p end
//   line_accept  0 = drop the line, emit nothing
//   pix_valid    pix_out valid
//   pix_ready    downstream takes the pixel
//   pix_out      current pixel
//   pix_last     marks the final pixel of the line
//   busy         high in SETUP or DRAW

localparam int RASTER_COORD_W = 16;

typedef struct packed {
   logic signed [RASTER_COORD_W-1:0] x;
   logic signed [RASTER_COORD_W-1:0] y;
} Point2D;

typedef struct packed {
   Point2D s;
   Point2D p;
} Line2D;

module line_raster #(
   parameter int COORD_W = RASTER_COORD_W
) (
   input  logic   clk,
   input  logic   rst,
   input  logic   line_valid,
   output logic   line_ready,
   input  Line2D  line_in,
   input  logic   line_accept,
   output logic   pix_valid,
   input  logic   pix_ready,
   output Point2D pix_out,
   output logic   pix_last,
   output logic   busy
);

   // Two extra bits hold |delta| up to 2^COORD_W-1 and 2*err without overflow.
   localparam int W = COORD_W + 2;

   typedef logic signed [COORD_W-1:0] coord_t;
   typedef logic signed [W-1:0]       acc_t;

   localparam coord_t ONE = coord_t'(1);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SETUP = 2'd1,
      DRAW  = 2'd2
   } state_t;

   state_t state, state_next;

   coord_t s_x, s_y, p_x, p_y;
   coord_t cur_x, cur_y;
   acc_t   dx, dy, err;
   logic   step_x_neg, step_y_neg;

   acc_t   diff_x, diff_y, abs_x, abs_y;
   acc_t   e2, err_step;
   coord_t nxt_x, nxt_y;
   logic   mv_x, mv_y;
   logic   end_hit;

   function automatic acc_t sext(input coord_t v);
      return {{(W-COORD_W){v[COORD_W-1]}}, v};
   endfunction

   // Line setup arithmetic and the single Bresenham step from the current point.
   always_comb begin
      diff_x = sext(p_x) - sext(s_x);
      diff_y = sext(p_y) - sext(s_y);
      abs_x  = diff_x[W-1] ? -diff_x : diff_x;
      abs_y  = diff_y[W-1] ? -diff_y : diff_y;

      e2   = err <<< 1;
      mv_x = (e2 >= dy);
      mv_y = (e2 <= dx);

      // Both decisions use the old err/e2. The err updates therefore accumulate
      // independently of each other.
      err_step = err;
      nxt_x    = cur_x;
      nxt_y    = cur_y;
      if (mv_x) begin
         err_step = err_step + dy;
         nxt_x    = step_x_neg ? (cur_x - ONE) : (cur_x + ONE);
      end
      if (mv_y) begin
         err_step = err_step + dx;
         nxt_y    = step_y_neg ? (cur_y - ONE) : (cur_y + ONE);
      end

`ifdef RASTER_INCLUSIVE_END_EN
      end_hit = (cur_x == p_x) && (cur_y == p_y);
`else
      // Half-open: the last emitted pixel is the one whose next step lands on p.
      end_hit = (nxt_x == p_x) && (nxt_y == p_y);
`endif
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   always_comb begin
      state_next = state;
      line_ready = 1'b0;
      pix_valid  = 1'b0;
      pix_last   = 1'b0;
      busy       = 1'b0;
      case (state)
         IDLE: begin
            line_ready = 1'b1;
            if (line_valid && line_accept) begin
               state_next = SETUP;
            end
         end
         SETUP: begin
            busy       = 1'b1;
            state_next = DRAW;
`ifndef RASTER_INCLUSIVE_END_EN
            if ((s_x == p_x) && (s_y == p_y)) begin
               state_next = IDLE;
            end
`endif
         end
         DRAW: begin
            busy      = 1'b1;
            pix_valid = 1'b1;
            pix_last  = end_hit;
            if (pix_ready && end_hit) begin
               state_next = IDLE;
            end
         end
         default: begin
            state_next = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         s_x        <= '0;
         s_y        <= '0;
         p_x        <= '0;
         p_y        <= '0;
         cur_x      <= '0;
         cur_y      <= '0;
         dx         <= '0;
         dy         <= '0;
         err        <= '0;
         step_x_neg <= 1'b0;
         step_y_neg <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (line_valid && line_accept) begin
                  s_x <= line_in.s.x;
                  s_y <= line_in.s.y;
                  p_x <= line_in.p.x;
                  p_y <= line_in.p.y;
               end
            end
            SETUP: begin
               dx         <= abs_x;
               dy         <= -abs_y;
               err        <= abs_x - abs_y;
               step_x_neg <= diff_x[W-1];
               step_y_neg <= diff_y[W-1];
               cur_x      <= s_x;
               cur_y      <= s_y;
            end
            DRAW: begin
               // A stalled pixel holds everything, so nothing is skipped or duplicated.
               if (pix_ready && !end_hit) begin
                  err   <= err_step;
                  cur_x <= nxt_x;
                  cur_y <= nxt_y;
               end
            end
            default: ;
         endcase
      end
   end

   assign pix_out = {cur_x, cur_y};

endmodule

// File: tb/tb_line_raster.sv
// tb/tb_line_raster.sv - self-checking bench for line_raster
`timescale 1ns/1ps
module tb_line_raster;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        line_valid = 1'b0;
   logic        line_accept = 1'b0;
   logic        pix_ready = 1'b1;
   logic [63:0] line_in = '0;
   logic        line_ready;
   logic        pix_valid;
   logic [31:0] pix_out;
   logic        pix_last;
   logic        busy;

   always #5 clk = ~clk;

   line_raster #(.COORD_W(16)) dut (
      .clk         (clk),
      .rst         (rst),
      .line_valid  (line_valid),
      .line_ready  (line_ready),
      .line_in     (line_in),
      .line_accept (line_accept),
      .pix_valid   (pix_valid),
      .pix_ready   (pix_ready),
      .pix_out     (pix_out),
      .pix_last    (pix_last),
      .busy        (busy)
   );

   typedef struct {
      int x;
      int y;
   } pt_t;

   pt_t gen_q[$];
   pt_t exp_q[$];

   int n_checks = 0;
   int n_errors = 0;
   int cyc = 0;
   int hs_cyc = 0;
   int line_idx = 0;
   int stall_left = 0;
   bit first_pending = 0;
   bit ready_next_chk = 0;
   bit rand_ready = 0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input int act, input int exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Reference walk: step from s by the Bresenham error rule until p is reached.
   // Under the half-open build the endpoint is then removed.
   task automatic gen_line(input int sx, input int sy, input int px, input int py);
      int dx, dy, stx, sty, err, e2, x, y;
      gen_q.delete();
      dx  = (px > sx) ? px - sx : sx - px;
      dy  = -((py > sy) ? py - sy : sy - py);
      stx = (px < sx) ? -1 : 1;
      sty = (py < sy) ? -1 : 1;
      err = dx + dy;
      x   = sx;
      y   = sy;
      for (int n = 0; n < 70000; n++) begin
         gen_q.push_back('{x: x, y: y});
         if (x == px && y == py) break;
         e2 = 2 * err;
         if (e2 >= dy) begin err += dy; x += stx; end
         if (e2 <= dx) begin err += dx; y += sty; end
      end
`ifndef RASTER_INCLUSIVE_END_EN
      void'(gen_q.pop_back());
`endif
   endtask

   task automatic pin_pt(input int idx, input int ex, input int ey);
      check("model_x", gen_q[idx].x, ex);
      check("model_y", gen_q[idx].y, ey);
   endtask

   task automatic send_line(input int sx, input int sy, input int px, input int py, input bit acc);
      int waitc;
      logic [15:0] a, b, c, d;
      @(negedge clk);
      a = sx[15:0]; b = sy[15:0]; c = px[15:0]; d = py[15:0];
      line_in     = {a, b, c, d};
      line_valid  = 1'b1;
      line_accept = acc;
      waitc = 0;
      while (!line_ready && waitc < 200) begin
         @(negedge clk);
         waitc++;
      end
      check("line_ready_wait", line_ready, 1);
      if (acc) begin
         gen_line(sx, sy, px, py);
         line_idx = 0;
         foreach (gen_q[i]) exp_q.push_back(gen_q[i]);
         if (gen_q.size() > 0) begin
            first_pending = 1;
            hs_cyc = cyc;
         end
      end
      @(negedge clk);
      line_valid  = 1'b0;
      line_accept = 1'b0;
   endtask

   task automatic wait_done();
      int w = 0;
      while ((exp_q.size() != 0 || !line_ready) && w < 1000) begin
         @(negedge clk);
         w++;
      end
      check("drain_timeout", int'(w < 1000), 1);
   endtask

   always @(posedge clk) begin
      #1;
      if (rand_ready) pix_ready = 1'($urandom_range(0, 1));
      else if (stall_left > 0 && pix_valid && line_idx == 1) begin
         pix_ready = 1'b0;
         stall_left--;
      end else pix_ready = 1'b1;
   end

   always @(negedge clk) begin
      if (!rst) begin
         if (ready_next_chk) begin
            check("line_ready_after_last", line_ready, 1);
            ready_next_chk = 0;
         end
         if (pix_valid) begin
            check("busy_in_draw", busy, 1);
            check("line_ready_in_draw", line_ready, 0);
            if (exp_q.size() == 0) begin
               n_checks++;
               n_errors++;
               $display("FAIL unexpected_pixel: got (%0d,%0d) expected no pixel (cycle %0d)",
                        $signed(pix_out[31:16]), $signed(pix_out[15:0]), cyc);
            end else begin
               check("pix_x", $signed(pix_out[31:16]), exp_q[0].x);
               check("pix_y", $signed(pix_out[15:0]), exp_q[0].y);
               check("pix_last", pix_last, int'(exp_q.size() == 1));
               if (first_pending) begin
                  check("first_latency", cyc - hs_cyc, 2);
                  first_pending = 0;
               end
               if (pix_ready) begin
                  if (exp_q.size() == 1) ready_next_chk = 1;
                  void'(exp_q.pop_front());
                  line_idx++;
               end
            end
         end else begin
            check("pix_last_idle", pix_last, 0);
         end
      end
   end

   initial begin
      int w;

      // Pin the reference walk with hand-derived sequences.
      gen_line(0, 0, 3, 0);
`ifdef RASTER_INCLUSIVE_END_EN
      check("model_len_h", gen_q.size(), 4);
      pin_pt(3, 3, 0);
`else
      check("model_len_h", gen_q.size(), 3);
`endif
      pin_pt(0, 0, 0); pin_pt(1, 1, 0); pin_pt(2, 2, 0);
      gen_line(2, 5, 0, 0);
`ifdef RASTER_INCLUSIVE_END_EN
      check("model_len_d", gen_q.size(), 6);
      pin_pt(5, 0, 0);
`else
      check("model_len_d", gen_q.size(), 5);
`endif
      pin_pt(0, 2, 5); pin_pt(1, 2, 4); pin_pt(2, 1, 3); pin_pt(3, 1, 2); pin_pt(4, 0, 1);
      gen_line(0, 0, 4, 2);
      pin_pt(0, 0, 0); pin_pt(1, 1, 1); pin_pt(2, 2, 1); pin_pt(3, 3, 2);
      gen_line(5, 5, 5, 5);
`ifdef RASTER_INCLUSIVE_END_EN
      check("model_len_z", gen_q.size(), 1);
`else
      check("model_len_z", gen_q.size(), 0);
`endif

      // Reset state, during and just after reset.
      repeat (3) @(negedge clk);
      check("rst_line_ready", line_ready, 1);
      check("rst_pix_valid", pix_valid, 0);
      check("rst_busy", busy, 0);
      check("rst_pix_out", int'(pix_out), 0);
      rst = 1'b0;
      @(negedge clk);
      check("post_rst_line_ready", line_ready, 1);
      check("post_rst_pix_last", pix_last, 0);

      // Horizontal line and steep diagonal-ish line back to back.
      send_line(0, 0, 3, 0, 1);
      send_line(2, 5, 0, 0, 1);
      wait_done();

      // A rejected line is consumed without output.
      send_line(1, 1, 7, 3, 0);
      for (int i = 0; i < 3; i++) begin
         check("drop_line_ready", line_ready, 1);
         check("drop_pix_valid", pix_valid, 0);
         @(negedge clk);
      end

      // Stall on the second pixel for three cycles.
      stall_left = 3;
      send_line(0, 0, 4, 2, 1);
      wait_done();
      check("stall_consumed", stall_left, 0);

      // Degenerate line.
      send_line(5, 5, 5, 5, 1);
      check("zero_setup_busy", busy, 1);
      @(negedge clk);
`ifndef RASTER_INCLUSIVE_END_EN
      check("zero_idle_ready", line_ready, 1);
      check("zero_idle_busy", busy, 0);
`endif
      wait_done();

      // Other octants with random backpressure.
      rand_ready = 1;
      send_line(-3, 2, 4, -5, 1);
      send_line(0, 0, -5, 2, 1);
      send_line(3, -1, -2, -7, 1);
      send_line(-4, -4, -4, 3, 1);
      wait_done();
      rand_ready = 0;

      // Reset in the middle of a 10-pixel line.
      send_line(0, 0, 9, 0, 1);
      w = 0;
      while (line_idx < 3 && w < 100) begin
         @(negedge clk);
         w++;
      end
      check("reach_mid_line", int'(w < 100), 1);
      @(posedge clk);
      #2;
      rst = 1'b1;
      exp_q.delete();
      first_pending = 0;
      ready_next_chk = 0;
      @(negedge clk);
      @(negedge clk);
      check("midrst_pix_valid", pix_valid, 0);
      check("midrst_busy", busy, 0);
      check("midrst_line_ready", line_ready, 1);
      check("midrst_pix_out", int'(pix_out), 0);
      rst = 1'b0;
      send_line(2, -3, -4, 1, 1);
      wait_done();

      repeat (3) @(negedge clk);
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
